// File: rtl/cmd_pkg.sv
// Shared constants and types for the command receive buffer.
package cmd_pkg;
  localparam int CMD_WORD_W   = 9;
  localparam int CMD_LAST_BIT = 8;
  localparam int CMD_LEN_W    = 11;  // holds lengths 1..2^BANK_AW for BANK_AW up to 10

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic                 bank;
    logic [CMD_LEN_W-1:0] len;
  } q_entry_t;
endpackage

// File: rtl/cmd_rx_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port
// (read-before-write when both ports hit the same word).
module cmd_rx_ram
  import cmd_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [CMD_WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [CMD_WORD_W-1:0] rdata_o
);
  logic [CMD_WORD_W-1:0] mem_q [2**AW];
  logic [CMD_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cmd_rx_buf.sv
// Command receive buffer: stores RX frames into a two-bank ping-pong RAM and
// publishes good frames through a two-entry queue. Define CMD_RX_STATS_EN to keep drop_cnt.
module cmd_rx_buf
  import cmd_pkg::*;
#(
  parameter int BANK_AW = 10,
  parameter int MIN_LEN = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_sof,
  input  logic                  rx_eof,
  input  logic                  rx_err,
  output logic                  frm_ready,
  output logic                  frm_bank,
  output logic [BANK_AW:0]      frm_len,
  input  logic                  frm_done,
  input  logic [BANK_AW-1:0]    rd_addr,
  output logic [CMD_WORD_W-1:0] rd_data,
  output logic [15:0]           drop_cnt
);
  localparam int LEN_W = BANK_AW + 1;
  localparam logic [LEN_W-1:0] BANK_WORDS = LEN_W'(1) << BANK_AW;

  rx_state_e        state_q, state_d;
  logic             bank_q, bank_d;
  logic [LEN_W-1:0] off_q, off_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       qcnt_q, qcnt_d;
  q_entry_t         q0_q, q0_d, q1_q, q1_d;
  q_entry_t         new_ent;

  logic               have_free, free_bank, overflow;
  logic               we, wr_bank, finish, publish, pop;
  logic [BANK_AW-1:0] wr_off;
  logic [LEN_W-1:0]   fin_len;
  logic [1:0]         drop_inc;

  // Banks still being filled are never marked full, so full_q alone picks the target.
  assign have_free = ~&full_q;
  assign free_bank = full_q[0];
  assign overflow  = (off_q == BANK_WORDS);
  assign pop       = frm_done && (qcnt_q != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        ST_RECV: begin
          if (rx_sof || !overflow) state_d = rx_eof ? ST_IDLE : ST_RECV;
          else                     state_d = rx_eof ? ST_IDLE : ST_DROP;
        end
        default: begin
          if (rx_sof)      state_d = rx_eof ? ST_IDLE : (have_free ? ST_RECV : ST_DROP);
          else if (rx_eof) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    we       = 1'b0;
    wr_bank  = bank_q;
    wr_off   = off_q[BANK_AW-1:0];
    finish   = 1'b0;
    fin_len  = off_q + 1'b1;
    off_d    = off_q;
    bank_d   = bank_q;
    drop_inc = 2'd0;
    publish  = 1'b0;
    if (rx_valid) begin
      if (state_q == ST_RECV) begin
        if (rx_sof) begin
          drop_inc = 2'd1;
          we       = 1'b1;
          wr_off   = '0;
          off_d    = LEN_W'(1);
          fin_len  = LEN_W'(1);
          finish   = rx_eof;
        end else if (overflow) begin
          drop_inc = 2'd1;
        end else begin
          we     = 1'b1;
          off_d  = off_q + 1'b1;
          finish = rx_eof;
        end
      end else if (rx_sof) begin
        if (have_free) begin
          we      = 1'b1;
          wr_bank = free_bank;
          bank_d  = free_bank;
          wr_off  = '0;
          off_d   = LEN_W'(1);
          fin_len = LEN_W'(1);
          finish  = rx_eof;
        end else begin
          drop_inc = 2'd1;
        end
      end
    end
    if (finish) begin
      if (rx_err || (32'(fin_len) < MIN_LEN)) drop_inc = drop_inc + 2'd1;
      else                                    publish  = 1'b1;
    end
  end

  // Entries beyond qcnt_q are kept zero so the head reads as 0 when empty.
  always_comb begin
    full_d       = full_q;
    q0_d         = q0_q;
    q1_d         = q1_q;
    qcnt_d       = qcnt_q;
    new_ent.bank = wr_bank;
    new_ent.len  = CMD_LEN_W'(fin_len);
    if (pop) begin
      full_d[q0_q.bank] = 1'b0;
      q0_d   = q1_q;
      q1_d   = '0;
      qcnt_d = qcnt_q - 2'd1;
    end
    if (publish) begin
      full_d[wr_bank] = 1'b1;
      if (qcnt_d == 2'd0) q0_d = new_ent;
      else                q1_d = new_ent;
      qcnt_d = qcnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= 1'b0;
      off_q  <= '0;
      full_q <= '0;
      qcnt_q <= '0;
      q0_q   <= '0;
      q1_q   <= '0;
    end else begin
      bank_q <= bank_d;
      off_q  <= off_d;
      full_q <= full_d;
      qcnt_q <= qcnt_d;
      q0_q   <= q0_d;
      q1_q   <= q1_d;
    end
  end

  assign frm_ready = (qcnt_q != 2'd0);
  assign frm_bank  = q0_q.bank;
  assign frm_len   = LEN_W'(q0_q.len);

  cmd_rx_ram #(.AW(BANK_AW + 1)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (we),
    .waddr_i ({wr_bank, wr_off}),
    .wdata_i ({rx_eof, rx_data}),
    .raddr_i ({frm_bank, rd_addr}),
    .rdata_o (rd_data)
  );

`ifdef CMD_RX_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop_inc;
  assign unused_drop_inc = ^drop_inc;
  assign drop_cnt        = 16'h0000;
`endif
endmodule
